// File: rtl/prog_load_ctrl_pkg.sv
// Shared definitions for the program-load controller: state encoding,
// assembly sizes and the default address width.
package prog_load_ctrl_pkg;

  localparam int unsigned LD_ADDR_LEN   = 32;
  localparam int unsigned LD_LINE_BYTES = 16;
  localparam int unsigned LD_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LD_HDR_I,
    LD_IMEM,
    LD_WR_I,
    LD_HDR_D,
    LD_DMEM,
    LD_WR_D,
    LD_DONE,
    LD_ERR
  } ld_state_e;

  // States in which a stream byte may be taken.
  function automatic logic ld_collecting(input ld_state_e s);
    return (s == LD_HDR_I) || (s == LD_IMEM) || (s == LD_HDR_D) || (s == LD_DMEM);
  endfunction

endpackage

// File: rtl/ld_byte_asm.sv
// N-byte little-endian assembler: byte k of a group lands in data[8k+7:8k].
// `full` flags the accept that completes an N-byte group.
module ld_byte_asm #(
  parameter int unsigned NBYTES = 16,
  localparam int unsigned CW = $clog2(NBYTES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic [8*NBYTES-1:0]   data,
  output logic [CW-1:0]         count,
  output logic                  full
);

  logic [8*NBYTES-1:0] data_q, data_d;
  logic [CW-1:0]       count_q, count_d;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign data_d[8*gi +: 8] = clear ? 8'd0 :
                                 (accept && count_q == CW'(gi)) ? byte_in :
                                 data_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (accept) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data  = data_q;
  assign count = count_q;
  assign full  = accept && (count_q == CW'(NBYTES - 1));

endmodule

// File: rtl/prog_load_ctrl.sv
// Boot-time loader: parses a little-endian byte stream into imem lines and
// dmem words, strobes the writes, and holds `loading` until the image is in.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_LEN   = LD_ADDR_LEN,
  parameter int unsigned IMEM_LINES = 512,
  parameter int unsigned DMEM_WORDS = 2048,
  parameter int unsigned DMEM_BASE  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic [ADDR_LEN-1:0] load_addr,
  output logic [127:0]        load_data,
  output logic                we_128,
  output logic                we_32,
  output logic                loading,
  output logic                done,
  output logic                error
);

  localparam int unsigned CW = $clog2(LD_LINE_BYTES);

  ld_state_e           state_q, state_d;
  logic [31:0]         n_q, n_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;

  logic [127:0]  asm_data;
  logic [CW-1:0] asm_count;
  logic          asm_full;
  logic          asm_clear;
  logic          take;
  logic          last4;
  logic [31:0]   hdr_val;

  assign take    = in_valid && ld_collecting(state_q);
  assign last4   = take && (asm_count == CW'(LD_WORD_BYTES - 1));
  // Completed header value including the byte being accepted this cycle.
  assign hdr_val = {in_data, asm_data[23:0]};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      LD_HDR_I: if (last4) begin
        n_d   = hdr_val;
        cnt_d = '0;
        if (hdr_val > 32'(IMEM_LINES)) state_d = LD_ERR;
        else if (hdr_val == 32'd0)     state_d = LD_HDR_D;
        else                           state_d = LD_IMEM;
      end
      LD_IMEM: if (take && asm_full) state_d = LD_WR_I;
      LD_WR_I: begin
        cnt_d   = cnt_q + 32'd1;
        addr_d  = addr_q + ADDR_LEN'(LD_LINE_BYTES);
        state_d = (cnt_q + 32'd1 < n_q) ? LD_IMEM : LD_HDR_D;
      end
      LD_HDR_D: if (last4) begin
        n_d    = hdr_val;
        cnt_d  = '0;
        addr_d = ADDR_LEN'(DMEM_BASE);
        if (hdr_val > 32'(DMEM_WORDS)) state_d = LD_ERR;
        else if (hdr_val == 32'd0)     state_d = LD_DONE;
        else                           state_d = LD_DMEM;
      end
      LD_DMEM: if (last4) state_d = LD_WR_D;
      LD_WR_D: begin
        cnt_d   = cnt_q + 32'd1;
        addr_d  = addr_q + ADDR_LEN'(LD_WORD_BYTES);
        state_d = (cnt_q + 32'd1 < n_q) ? LD_DMEM : LD_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // The assembler keeps its contents through WR_* so the write can use them.
  assign asm_clear = (state_d != state_q) && ld_collecting(state_d);

  ld_byte_asm #(.NBYTES(LD_LINE_BYTES)) u_asm (
    .clk     (clk),
    .reset   (reset),
    .clear   (asm_clear),
    .accept  (take),
    .byte_in (in_data),
    .data    (asm_data),
    .count   (asm_count),
    .full    (asm_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_HDR_I;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign in_ready  = ld_collecting(state_q);
  assign we_128    = (state_q == LD_WR_I);
  assign we_32     = (state_q == LD_WR_D);
  assign done      = (state_q == LD_DONE);
  assign error     = (state_q == LD_ERR);
  assign loading   = (state_q != LD_DONE);
  assign load_addr = addr_q;
  assign load_data = (state_q == LD_WR_D) ? {asm_data[31:0], 96'd0} : asm_data;

endmodule
